// File: rtl/multichannel_amp_ramp.sv
`default_nettype none
// ============================================================================
// multichannel_amp_ramp: time-multiplexed VCA, one shared signed multiplier,
// per-channel amplitude slew toward target. Revision: 1.0
// ============================================================================
module multichannel_amp_ramp #(
  parameter int DATA_BITS      = 12,
  parameter int AMPLITUDE_BITS = 8,
  parameter int CHANNELS       = 4,
  parameter int RAMP_STEP      = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                sample_en,
  input  logic [CHANNELS*DATA_BITS-1:0]       din,
  input  logic [CHANNELS*AMPLITUDE_BITS-1:0]  amplitude,
  output logic [CHANNELS*DATA_BITS-1:0]       dout,
  output logic                                dout_valid,
  output logic                                busy,
  output logic                                overrun
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);
  localparam logic [DATA_BITS-1:0] MID = {1'b1, {(DATA_BITS-1){1'b0}}};
  // Steps at or beyond full scale behave identically, so saturate to keep A+1 bits.
  localparam logic [AMPLITUDE_BITS:0] STEP_SAT =
    (RAMP_STEP >= (1 << AMPLITUDE_BITS)) ? (AMPLITUDE_BITS+1)'(1 << AMPLITUDE_BITS)
                                         : (AMPLITUDE_BITS+1)'(RAMP_STEP);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [DATA_BITS-1:0]          din_q    [CHANNELS];
  logic [DATA_BITS-1:0]          din_d    [CHANNELS];
  logic [AMPLITUDE_BITS-1:0]     tgt_q    [CHANNELS];
  logic [AMPLITUDE_BITS-1:0]     tgt_d    [CHANNELS];
  logic [AMPLITUDE_BITS-1:0]     cur_q    [CHANNELS];
  logic [AMPLITUDE_BITS-1:0]     cur_d    [CHANNELS];
  logic [DATA_BITS-1:0]          shadow_q [CHANNELS];
  logic [DATA_BITS-1:0]          shadow_d [CHANNELS];
  logic [CHANNELS*DATA_BITS-1:0] dout_q, dout_d;
  logic                          dout_valid_q, dout_valid_d;
  logic                          busy_q, busy_d;
  logic                          overrun_q, overrun_d;

  logic [AMPLITUDE_BITS-1:0]               cur_sel, tgt_sel, cur_new;
  logic signed [DATA_BITS-1:0]             smp;
  logic signed [AMPLITUDE_BITS:0]          amp_s;
  logic signed [DATA_BITS+AMPLITUDE_BITS-1:0] prod;
  logic [DATA_BITS-1:0]                    result;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    din_d        = din_q;
    tgt_d        = tgt_q;
    cur_d        = cur_q;
    shadow_d     = shadow_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    overrun_d    = sample_en && (state_q != IDLE);

    cur_sel = cur_q[idx_q];
    tgt_sel = tgt_q[idx_q];
    if (RAMP_STEP == 0 || cur_sel == tgt_sel) begin
      cur_new = tgt_sel;
    end else if (cur_sel < tgt_sel) begin
      if ({1'b0, tgt_sel - cur_sel} <= STEP_SAT) cur_new = tgt_sel;
      else cur_new = AMPLITUDE_BITS'({1'b0, cur_sel} + STEP_SAT);
    end else begin
      if ({1'b0, cur_sel - tgt_sel} <= STEP_SAT) cur_new = tgt_sel;
      else cur_new = AMPLITUDE_BITS'({1'b0, cur_sel} - STEP_SAT);
    end

    // Offset binary to two's complement, scale by the freshly slewed amplitude, floor back.
    smp    = signed'(din_q[idx_q] ^ MID);
    amp_s  = signed'({1'b0, cur_new});
    prod   = (DATA_BITS+AMPLITUDE_BITS)'(smp) * (DATA_BITS+AMPLITUDE_BITS)'(amp_s);
    result = DATA_BITS'(prod >>> AMPLITUDE_BITS) ^ MID;

    case (state_q)
      IDLE: begin
        if (sample_en) begin
          for (int k = 0; k < CHANNELS; k++) begin
            din_d[k] = din[k*DATA_BITS +: DATA_BITS];
            tgt_d[k] = amplitude[k*AMPLITUDE_BITS +: AMPLITUDE_BITS];
          end
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        cur_d[idx_q]    = cur_new;
        shadow_d[idx_q] = result;
        if (idx_q == LAST_IDX) state_d = DONE;
        else idx_d = idx_q + 1'b1;
      end
      DONE: begin
        for (int k = 0; k < CHANNELS; k++) dout_d[k*DATA_BITS +: DATA_BITS] = shadow_q[k];
        dout_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      dout_q       <= {CHANNELS{MID}};
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        din_q[k]    <= '0;
        tgt_q[k]    <= '0;
        cur_q[k]    <= '0;
        shadow_q[k] <= MID;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      din_q        <= din_d;
      tgt_q        <= tgt_d;
      cur_q        <= cur_d;
      shadow_q     <= shadow_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: doc/multichannel_amp_ramp.md
# multichannel_amp_ramp

Time-multiplexed, multi-channel VCA stage. It scales CHANNELS offset-binary voice samples by per-channel 8-bit amplitudes using one shared signed multiplier. Each channel's applied amplitude slews toward its target by a fixed step per sample, which suppresses zipper noise. It sits between the per-voice envelope/waveform outputs and the mixer, with one pass per sample strobe.

## Interface
- DATA_BITS, 12, sample width (offset binary, midscale = 2^(DATA_BITS-1))
- AMPLITUDE_BITS, 8, amplitude width (unsigned)
- CHANNELS, 4, number of channels (≥1)
- RAMP_STEP, 1, amplitude slew per sample; 0 = bypass (applied amplitude = target)

- clk  input  1  clock; one clock domain
- rst  input  1  reset, asynchronous, active-high
- sample_en  input  1  one-cycle strobe that starts a pass
- din  input  CHANNELS*DATA_BITS  channel k at [k*DATA_BITS +: DATA_BITS]
- amplitude  input  CHANNELS*AMPLITUDE_BITS  target amplitude, channel k at [k*AMPLITUDE_BITS +: AMPLITUDE_BITS]
- dout  output  CHANNELS*DATA_BITS  scaled samples, offset binary, same packing as din
- dout_valid  output  1  one-cycle pulse when dout updates
- busy  output  1  high while state ≠ IDLE
- overrun  output  1  one-cycle pulse when sample_en is ignored

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE + sample_en: capture all of din and amplitude into internal registers, set idx=0, go to RUN.
- RUN: each cycle processes channel idx.
  - Ramp: if cur[idx]<tgt[idx], cur = min(cur+RAMP_STEP, tgt). If cur>tgt, cur = max(cur−RAMP_STEP, tgt). RAMP_STEP=0 sets cur=tgt. Arithmetic is AMPLITUDE_BITS+1 wide, so the slew never wraps.
  - Multiply: s = din ^ 2^(DATA_BITS-1), taken as signed. Product = s × {1'b0, cur_new}, signed, DATA_BITS+AMPLITUDE_BITS bits. The result uses the **updated** amplitude.
  - Result = product[DATA_BITS+AMPLITUDE_BITS-1 -: DATA_BITS] ^ 2^(DATA_BITS-1), written to shadow[idx]. This is a floor divide by 2^AMPLITUDE_BITS. Amplitude 0 gives exact midscale.
  - idx==CHANNELS−1: go to DONE. Otherwise idx++.
- DONE: load all of dout from shadow in one step, pulse dout_valid, go to IDLE. dout never shows a partial pass.
- sample_en while state ≠ IDLE: ignored, no capture, overrun pulses the next cycle.
- Inputs are sampled only on the capture edge. Changes to din or amplitude during a pass have no effect until the next pass.
- cur[] persists across passes. This register is the ramp state.

## Timing
- Capture edge t0. Channel k is processed at edge t(k+1). DONE is reached after edge tCHANNELS.
- dout and dout_valid are updated at edge t(CHANNELS+1), giving a latency of CHANNELS+1 clocks from the capture edge.
- busy is high after t0 until after t(CHANNELS+1). A sample_en in the first cycle with busy low is accepted. The minimum strobe period is CHANNELS+2 clocks.
- All outputs are registered.
- Reset values: dout = all channels 2^(DATA_BITS-1), dout_valid=0, busy=0, overrun=0, cur[]=0, shadow=midscale, state=IDLE.
- Reset mid-pass aborts the pass. No dout_valid is issued, dout returns to midscale, and cur[] is cleared.

## Test plan
- Reset (12/8/4, step 16): after rst is released, dout = 0x800 on all channels and dout_valid = busy = overrun = 0. Assert rst mid-RUN: no dout_valid follows, and dout = 0x800.
- Bypass (RAMP_STEP=0), single pass per case:
  - din 0xFFF, amp 0xFF → 0xFF7.
  - din 0x000, amp 0xFF → 0x008.
  - din 0xC00, amp 0x80 → 0xA00.
  - Any din, amp 0x00 → 0x800.
- Ramp up (step 16): din 0xC00, target 0xFF held constant.
  - Successive passes give 0x840, 0x880, … 0xBC0 (amp 240).
  - 16th pass (amp 255) gives 0xBFC and stays there.
- Ramp down and mixed directions: pre-settle ch0 at 0xFF and ch1 at 0x00, then swap targets. After one pass, ch0 uses amp 0xEF and ch1 uses amp 0x10, with independent per-channel cur[].
- Handshake: sample_en at t0 → busy high from t0, dout_valid exactly at t5, single cycle.
  - sample_en at t2 → overrun pulse and no extra pass.
  - sample_en in the first cycle after busy falls → accepted.
- Input isolation: change din and amplitude at t2 → outputs of the current pass reflect the t0 captured values.
